// File: rtl/axi_burst_slave.sv
// axi_burst_slave: memory-backed burst slave for the bus master's read and
// write channels. Read and write FSMs run independently over a shared
// 256x8 byte store. Every output is registered.
// Optional feature: define SLV_RANGE_CHECK_EN to flag any beat whose byte
// address is >= LIMIT. Flagged reads return {8'h00, 1'b1} and flagged
// writes are dropped. Without the macro, all 256 addresses are valid.
module axi_burst_slave #(
    parameter logic [7:0] LIMIT = 8'hC0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ARVALID,
    input  logic [15:0] ARIN,
    output logic        ARREADY,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [8:0]  ROUT,
    output logic        RLAST,
    input  logic        AWVALID,
    input  logic [11:0] AWIN,
    output logic        AWREADY,
    input  logic        WVALID,
    input  logic [7:0]  WDATA,
    input  logic        WLAST,
    output logic        WREADY,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [4:0]  BRESP
);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;

    // Byte store. It is not reset, so bytes written before a reset survive it.
    logic [7:0] mem [0:255];

    // Read channel state
    rd_state_t  rd_state_reg, rd_state_next;
    logic [7:0] rd_addr_reg, rd_addr_next;
    logic [3:0] rd_len_reg, rd_len_next;
    logic [3:0] rd_beat_reg, rd_beat_next;
    logic       arready_reg, arready_next;
    logic       rvalid_reg, rvalid_next;
    logic       rlast_reg, rlast_next;
    logic [8:0] rout_reg, rout_next;

    // Write channel state
    wr_state_t  wr_state_reg, wr_state_next;
    logic [7:0] wr_addr_reg, wr_addr_next;
    logic [3:0] wr_id_reg, wr_id_next;
    logic [3:0] wr_beat_reg, wr_beat_next;
    logic       wr_err_reg, wr_err_next;
    logic       awready_reg, awready_next;
    logic       wready_reg, wready_next;
    logic       bvalid_reg, bvalid_next;
    logic [4:0] bresp_reg, bresp_next;

    // Read fetch path and write beat qualifiers
    logic [7:0] rd_fetch_addr;
    logic       rd_fetch_bad;
    logic [8:0] rd_fetch_word;
    logic       wr_bad;
    logic       wr_fire;
    logic       wr_en;
    logic       wr_final;
    logic       wr_beat_err;

    // The read ID has no return path on this channel.
    logic [3:0] unused_ar_id;
    assign unused_ar_id = ARIN[3:0];

    // The fetch reads the latched address in R_FETCH. In R_DATA it reads the
    // following byte so that the next beat is loaded on the handshake edge.
    assign rd_fetch_addr = (rd_state_reg == R_DATA) ? rd_addr_reg + 8'd1 : rd_addr_reg;

`ifdef SLV_RANGE_CHECK_EN
    assign rd_fetch_bad = (rd_fetch_addr >= LIMIT);
    assign wr_bad       = (wr_addr_reg >= LIMIT);
`else
    logic [7:0] unused_limit;
    assign unused_limit = LIMIT;
    assign rd_fetch_bad = 1'b0;
    assign wr_bad       = 1'b0;
`endif

    assign rd_fetch_word = rd_fetch_bad ? 9'h001 : {mem[rd_fetch_addr], 1'b0};

    assign wr_fire     = (wr_state_reg == W_DATA) && WVALID && wready_reg;
    assign wr_en       = wr_fire && !wr_bad;
    assign wr_final    = WLAST || (wr_beat_reg == 4'd15);
    assign wr_beat_err = wr_bad || ((wr_beat_reg == 4'd15) && !WLAST);

    assign ARREADY = arready_reg;
    assign RVALID  = rvalid_reg;
    assign ROUT    = rout_reg;
    assign RLAST   = rlast_reg;
    assign AWREADY = awready_reg;
    assign WREADY  = wready_reg;
    assign BVALID  = bvalid_reg;
    assign BRESP   = bresp_reg;

    // Memory write port. The read side samples before this update, so a
    // same-cycle fetch of the same address returns the old byte.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_reg] <= WDATA;
        end
    end

    // Read channel registers. Reset aborts any in-flight burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_reg <= R_IDLE;
            rd_addr_reg  <= 8'd0;
            rd_len_reg   <= 4'd0;
            rd_beat_reg  <= 4'd0;
            arready_reg  <= 1'b1;
            rvalid_reg   <= 1'b0;
            rlast_reg    <= 1'b0;
            rout_reg     <= 9'd0;
        end else begin
            rd_state_reg <= rd_state_next;
            rd_addr_reg  <= rd_addr_next;
            rd_len_reg   <= rd_len_next;
            rd_beat_reg  <= rd_beat_next;
            arready_reg  <= arready_next;
            rvalid_reg   <= rvalid_next;
            rlast_reg    <= rlast_next;
            rout_reg     <= rout_next;
        end
    end

    // Read channel next state
    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            R_IDLE:  if (ARVALID && arready_reg) rd_state_next = R_FETCH;
            R_FETCH: rd_state_next = R_DATA;
            R_DATA:  if (rvalid_reg && RREADY && rlast_reg) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Read channel datapath and output next values
    always_comb begin
        rd_addr_next = rd_addr_reg;
        rd_len_next  = rd_len_reg;
        rd_beat_next = rd_beat_reg;
        arready_next = arready_reg;
        rvalid_next  = rvalid_reg;
        rlast_next   = rlast_reg;
        rout_next    = rout_reg;
        case (rd_state_reg)
            R_IDLE: begin
                if (ARVALID && arready_reg) begin
                    rd_addr_next = ARIN[15:8];
                    rd_len_next  = ARIN[7:4];
                    rd_beat_next = 4'd0;
                    arready_next = 1'b0;
                end
            end
            R_FETCH: begin
                rout_next   = rd_fetch_word;
                rvalid_next = 1'b1;
                rlast_next  = (rd_len_reg == 4'd0);
            end
            R_DATA: begin
                if (rvalid_reg && RREADY) begin
                    if (rlast_reg) begin
                        rvalid_next  = 1'b0;
                        rlast_next   = 1'b0;
                        arready_next = 1'b1;
                    end else begin
                        rd_addr_next = rd_addr_reg + 8'd1;
                        rd_beat_next = rd_beat_reg + 4'd1;
                        rout_next    = rd_fetch_word;
                        rlast_next   = ((rd_beat_reg + 4'd1) == rd_len_reg);
                    end
                end
            end
            default: ;
        endcase
    end

    // Write channel registers. Reset aborts any in-flight burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_reg <= W_IDLE;
            wr_addr_reg  <= 8'd0;
            wr_id_reg    <= 4'd0;
            wr_beat_reg  <= 4'd0;
            wr_err_reg   <= 1'b0;
            awready_reg  <= 1'b1;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= 5'd0;
        end else begin
            wr_state_reg <= wr_state_next;
            wr_addr_reg  <= wr_addr_next;
            wr_id_reg    <= wr_id_next;
            wr_beat_reg  <= wr_beat_next;
            wr_err_reg   <= wr_err_next;
            awready_reg  <= awready_next;
            wready_reg   <= wready_next;
            bvalid_reg   <= bvalid_next;
            bresp_reg    <= bresp_next;
        end
    end

    // Write channel next state
    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            W_IDLE: if (AWVALID && awready_reg) wr_state_next = W_DATA;
            W_DATA: if (wr_fire && wr_final) wr_state_next = W_RESP;
            W_RESP: if (bvalid_reg && BREADY) wr_state_next = W_IDLE;
            default: wr_state_next = W_IDLE;
        endcase
    end

    // Write channel datapath and output next values
    always_comb begin
        wr_addr_next = wr_addr_reg;
        wr_id_next   = wr_id_reg;
        wr_beat_next = wr_beat_reg;
        wr_err_next  = wr_err_reg;
        awready_next = awready_reg;
        wready_next  = wready_reg;
        bvalid_next  = bvalid_reg;
        bresp_next   = bresp_reg;
        case (wr_state_reg)
            W_IDLE: begin
                if (AWVALID && awready_reg) begin
                    wr_addr_next = AWIN[11:4];
                    wr_id_next   = AWIN[3:0];
                    wr_beat_next = 4'd0;
                    wr_err_next  = 1'b0;
                    awready_next = 1'b0;
                    wready_next  = 1'b1;
                end
            end
            W_DATA: begin
                if (wr_fire) begin
                    wr_addr_next = wr_addr_reg + 8'd1;
                    wr_beat_next = wr_beat_reg + 4'd1;
                    wr_err_next  = wr_err_reg || wr_beat_err;
                    if (wr_final) begin
                        wready_next = 1'b0;
                        bvalid_next = 1'b1;
                        bresp_next  = {wr_id_reg, wr_err_reg || wr_beat_err};
                    end
                end
            end
            W_RESP: begin
                if (bvalid_reg && BREADY) begin
                    bvalid_next  = 1'b0;
                    bresp_next   = 5'd0;
                    awready_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_burst_slave.sv
// Self-checking bench for axi_burst_slave. A byte-array model of the store,
// updated per accepted write beat, predicts every read beat and response.
module tb_axi_burst_slave;

    localparam logic [7:0] LIMIT = 8'hC0;

    logic        clk = 1'b0;
    logic        rst;
    logic        ARVALID;
    logic [15:0] ARIN;
    logic        ARREADY;
    logic        RVALID;
    logic        RREADY;
    logic [8:0]  ROUT;
    logic        RLAST;
    logic        AWVALID;
    logic [11:0] AWIN;
    logic        AWREADY;
    logic        WVALID;
    logic [7:0]  WDATA;
    logic        WLAST;
    logic        WREADY;
    logic        BVALID;
    logic        BREADY;
    logic [4:0]  BRESP;

    int checks = 0;
    int fails  = 0;

    logic [7:0] model_mem [256];

    always #5 clk = ~clk;

    axi_burst_slave #(.LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ARVALID(ARVALID), .ARIN(ARIN), .ARREADY(ARREADY),
        .RVALID(RVALID), .RREADY(RREADY), .ROUT(ROUT), .RLAST(RLAST),
        .AWVALID(AWVALID), .AWIN(AWIN), .AWREADY(AWREADY),
        .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    function automatic bit addr_bad(input logic [7:0] a);
`ifdef SLV_RANGE_CHECK_EN
        return a >= LIMIT;
`else
        return 1'b0;
`endif
    endfunction

    // One write burst: AW handshake, nbeats data beats, then the B response
    // after bdelay cycles of BREADY low.
    task automatic wr_burst(input logic [7:0] addr, input logic [3:0] id,
                            input logic [7:0] data [17], input int nbeats,
                            input bit give_last, input int bdelay, input bit gaps);
        int t;
        bit err;
        int accepted;
        bit last_beat;
        bit final_beat;
        logic [7:0] a;
        logic [4:0] exp_bresp;
        err = 0;
        accepted = 0;
        BREADY = 0;
        @(negedge clk);
        AWVALID = 1;
        AWIN = {addr, id};
        t = 0;
        while (AWREADY !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (AWREADY !== 1'b1) begin
            fails++;
            $display("FAIL aw_wait: AWREADY=%b required 1 within 100 cycles", AWREADY);
            AWVALID = 0;
            return;
        end
        @(negedge clk);
        AWVALID = 0;
        checks++;
        if ({AWREADY, WREADY} !== 2'b01) begin
            fails++;
            $display("FAIL aw_accept: AWREADY,WREADY=%b required 01", {AWREADY, WREADY});
        end
        for (int i = 0; i < nbeats && i < 16; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            last_beat = give_last && (i == nbeats - 1);
            WVALID = 1;
            WDATA = data[i];
            WLAST = last_beat;
            checks++;
            if (WREADY !== 1'b1) begin
                fails++;
                $display("FAIL w_ready: beat %0d WREADY=%b required 1", i, WREADY);
            end
            @(posedge clk);
            a = addr + 8'(i);
            if (addr_bad(a)) err = 1;
            else model_mem[a] = data[i];
            accepted++;
            final_beat = last_beat || (i == 15);
            if (i == 15 && !last_beat) err = 1;
            @(negedge clk);
            WVALID = 0;
            WLAST = 0;
            checks++;
            if ({BVALID, WREADY} !== (final_beat ? 2'b10 : 2'b01)) begin
                fails++;
                $display("FAIL w_beat: beat %0d BVALID,WREADY=%b required %b", i,
                         {BVALID, WREADY}, final_beat ? 2'b10 : 2'b01);
            end
            if (final_beat) break;
        end
        // Beats offered past the 16-beat limit must be refused.
        if (accepted == 16 && nbeats > 16) begin
            WVALID = 1;
            WDATA = data[16];
            repeat (2) begin
                checks++;
                if (WREADY !== 1'b0) begin
                    fails++;
                    $display("FAIL w_overflow: WREADY=%b required 0 after 16 beats", WREADY);
                end
                @(negedge clk);
            end
            WVALID = 0;
        end
        exp_bresp = {id, err};
        for (int k = 0; k < bdelay; k++) begin
            checks++;
            if ({BVALID, BRESP} !== {1'b1, exp_bresp}) begin
                fails++;
                $display("FAIL b_hold: BVALID,BRESP=%b_%h required 1_%h", BVALID, BRESP, exp_bresp);
            end
            @(negedge clk);
        end
        checks++;
        if ({BVALID, BRESP} !== {1'b1, exp_bresp}) begin
            fails++;
            $display("FAIL b_resp: BVALID,BRESP=%b_%h required 1_%h", BVALID, BRESP, exp_bresp);
        end
        BREADY = 1;
        @(posedge clk);
        @(negedge clk);
        BREADY = 0;
        checks++;
        if ({BVALID, BRESP, AWREADY} !== {1'b0, 5'd0, 1'b1}) begin
            fails++;
            $display("FAIL b_done: BVALID,BRESP,AWREADY=%b_%h_%b required 0_00_1", BVALID, BRESP, AWREADY);
        end
        $display("WR addr=%02h id=%h beats=%0d accepted=%0d bresp=%02h", addr, id, nbeats, accepted, exp_bresp);
    endtask

    // One read burst of len+1 beats with optional RREADY stalls.
    task automatic rd_burst(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                            input int stall_beat, input int stall_len, input bit rnd_stall);
        int t;
        int n_stall;
        logic [7:0] a;
        logic [8:0] exp_word;
        bit exp_last;
        RREADY = 0;
        @(negedge clk);
        ARVALID = 1;
        ARIN = {addr, len, id};
        t = 0;
        while (ARREADY !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (ARREADY !== 1'b1) begin
            fails++;
            $display("FAIL ar_wait: ARREADY=%b required 1 within 100 cycles", ARREADY);
            ARVALID = 0;
            return;
        end
        @(negedge clk);
        ARVALID = 0;
        checks++;
        if ({ARREADY, RVALID} !== 2'b00) begin
            fails++;
            $display("FAIL ar_accept: ARREADY,RVALID=%b required 00", {ARREADY, RVALID});
        end
        @(negedge clk);
        for (int b = 0; b <= int'(len); b++) begin
            a = addr + 8'(b);
            exp_word = addr_bad(a) ? 9'h001 : {model_mem[a], 1'b0};
            exp_last = (b == int'(len));
            n_stall = (b == stall_beat) ? stall_len : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            RREADY = 0;
            for (int k = 0; k < n_stall; k++) begin
                checks++;
                if ({RVALID, RLAST, ROUT} !== {1'b1, exp_last, exp_word}) begin
                    fails++;
                    $display("FAIL r_stall: beat %0d RVALID,RLAST,ROUT=%b_%b_%h required 1_%b_%h",
                             b, RVALID, RLAST, ROUT, exp_last, exp_word);
                end
                @(negedge clk);
            end
            RREADY = 1;
            checks++;
            if ({RVALID, RLAST, ROUT} !== {1'b1, exp_last, exp_word}) begin
                fails++;
                $display("FAIL r_beat: beat %0d RVALID,RLAST,ROUT=%b_%b_%h required 1_%b_%h",
                         b, RVALID, RLAST, ROUT, exp_last, exp_word);
            end
            @(posedge clk);
            @(negedge clk);
        end
        RREADY = 0;
        checks++;
        if ({RVALID, RLAST, ARREADY} !== 3'b001) begin
            fails++;
            $display("FAIL r_done: RVALID,RLAST,ARREADY=%b required 001", {RVALID, RLAST, ARREADY});
        end
        $display("RD addr=%02h len=%0d id=%h", addr, len, id);
    endtask

    task automatic test_reset();
        rst = 1;
        ARVALID = 0; ARIN = 0; RREADY = 0;
        AWVALID = 0; AWIN = 0; WVALID = 0; WDATA = 0; WLAST = 0; BREADY = 0;
        #1;
        checks++;
        if ({ARREADY, AWREADY, RVALID, RLAST, ROUT, WREADY, BVALID, BRESP} !== {2'b11, 18'd0}) begin
            fails++;
            $display("FAIL reset_values: outputs=%h required %h",
                     {ARREADY, AWREADY, RVALID, RLAST, ROUT, WREADY, BVALID, BRESP}, {2'b11, 18'd0});
        end
        repeat (2) @(negedge clk);
        rst = 0;
        $display("RESET released");
    endtask

    // Fill the whole store so every later read has a known expectation.
    task automatic test_fill();
        logic [7:0] d [17];
        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 17; i++) d[i] = 8'($urandom);
            wr_burst(8'(blk * 16), 4'(blk), d, 16, 1, 0, 0);
        end
    endtask

    task automatic test_write_basic();
        logic [7:0] d [17];
        for (int i = 0; i < 17; i++) d[i] = 8'h00;
        d[0] = 8'hAA; d[1] = 8'hBB; d[2] = 8'hCC; d[3] = 8'hDD;
        wr_burst(8'h10, 4'h3, d, 4, 1, 0, 0);
    endtask

    task automatic test_read_basic();
        rd_burst(8'h10, 4'd3, 4'h5, -1, 0, 0);
    endtask

    task automatic test_wrap();
        logic [7:0] d [17];
        for (int i = 0; i < 17; i++) d[i] = 8'h00;
        d[0] = 8'h11; d[1] = 8'h22;
        wr_burst(8'hFF, 4'h7, d, 2, 1, 1, 0);
        rd_burst(8'hFF, 4'd1, 4'h0, -1, 0, 0);
    endtask

    task automatic test_backpressure();
        rd_burst(8'h10, 4'd3, 4'h2, 1, 3, 0);
    endtask

    task automatic test_overflow();
        logic [7:0] d [17];
        for (int i = 0; i < 17; i++) d[i] = 8'($urandom);
        wr_burst(8'h40, 4'h9, d, 17, 0, 2, 0);
        rd_burst(8'h4F, 4'd1, 4'h1, -1, 0, 0);
    endtask

    task automatic test_range();
        logic [7:0] d [17];
        for (int i = 0; i < 17; i++) d[i] = 8'($urandom);
        rd_burst(8'hBF, 4'd1, 4'h0, -1, 0, 0);
        wr_burst(8'hBE, 4'h4, d, 4, 1, 0, 0);
        rd_burst(8'hBD, 4'd4, 4'h0, -1, 0, 1);
    endtask

    task automatic test_concurrent();
        logic [7:0] d [17];
        for (int i = 0; i < 17; i++) d[i] = 8'($urandom);
        fork
            rd_burst(8'h20, 4'd7, 4'h6, -1, 0, 1);
            wr_burst(8'h80, 4'hA, d, 8, 1, 1, 1);
        join
        rd_burst(8'h80, 4'd7, 4'h6, -1, 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] d [17];
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 17; i++) d[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 0)
                wr_burst(8'($urandom), 4'($urandom), d, int'($urandom_range(1, 16)), 1,
                         int'($urandom_range(0, 3)), 1);
            else
                rd_burst(8'($urandom), 4'($urandom), 4'($urandom), -1, 0, 1);
        end
    endtask

    // Reset asserted between clock edges with both channels mid-burst.
    task automatic test_reset_mid_burst();
        logic [7:0] d0, d1;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        @(negedge clk);
        ARVALID = 1; ARIN = {8'h30, 4'd7, 4'h1};
        AWVALID = 1; AWIN = {8'h60, 4'h2};
        @(posedge clk);
        @(negedge clk);
        ARVALID = 0; AWVALID = 0;
        WVALID = 1; WDATA = d0; WLAST = 0;
        @(posedge clk);
        model_mem[8'h60] = d0;
        @(negedge clk);
        WDATA = d1;
        @(posedge clk);
        model_mem[8'h61] = d1;
        @(negedge clk);
        WVALID = 0;
        RREADY = 1;
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        checks++;
        if ({ARREADY, AWREADY, RVALID, RLAST, ROUT, WREADY, BVALID, BRESP} !== {2'b11, 18'd0}) begin
            fails++;
            $display("FAIL reset_mid_burst: outputs=%h required %h",
                     {ARREADY, AWREADY, RVALID, RLAST, ROUT, WREADY, BVALID, BRESP}, {2'b11, 18'd0});
        end
        @(negedge clk);
        RREADY = 0;
        @(negedge clk);
        rst = 0;
        $display("RST mid-burst asserted and released");
        rd_burst(8'h60, 4'd2, 4'h3, -1, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_write_basic();
        test_read_basic();
        test_wrap();
        test_backpressure();
        test_overflow();
        test_range();
        test_concurrent();
        test_random();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
